// File: rtl/mips_define.sv
// mips_define: shared fetch-unit constants (address width, default depth, reset and exception vectors)
package mips_define;
  localparam int XLEN = 64;
  localparam int DEPTH_DEF = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h0;
  localparam logic [XLEN-1:0] EXC_PC_DEF = 64'h80;
endpackage

// File: rtl/structures.sv
// structures: entry record carried from the fetch queue to the IF/ID boundary
package structures;
  import mips_define::*;
  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            fetch_err;
  } fetch_entry_t;
endpackage

// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: synchronous FIFO of fetch entries with flush and occupancy outputs
module mips_fetch_queue
  import structures::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  output fetch_entry_t  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // status flags and head read; overflowing pushes and empty pops are ignored
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    do_push = push & ~full;
    do_pop = pop & ~empty;
    dout = mem[rd_ptr];
  end

  // pointer/occupancy update; flush behaves like reset for the control state
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC owner and in-order instruction fetch with redirect handling; MIPS_FETCH_BYPASS_EN enables same-cycle response bypass
module mips_fetch_unit
  import mips_define::*;
  import structures::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] EXC_PC = EXC_PC_DEF
)(
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            except_valid,
  input  logic            eret_valid,
  input  logic [XLEN-1:0] epc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            id_fetch_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = CW + 1;
  logic [XLEN-1:0] pc, target;
  logic [CW-1:0] outstanding, drop_cnt, occ, sh_count;
  logic [IW-1:0] inflight;
  logic halted, redir, req_fire, rsp_keep, err_push, bypass;
  logic q_push, q_pop, q_empty, q_full, sh_empty, sh_full;
  fetch_entry_t q_din, q_head, sh_din, sh_head, rsp_e, id_sel;

  mips_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clk), .rst_n(rst_n), .flush(redir), .push(q_push), .din(q_din), .pop(q_pop),
    .dout(q_head), .full(q_full), .empty(q_empty), .count(occ)
  );

  // pc of every live request, popped as its response is kept; stale entries vanish with the flush
  mips_fetch_queue #(.DEPTH(DEPTH)) u_shadow (
    .clk(clk), .rst_n(rst_n), .flush(redir), .push(req_fire), .din(sh_din), .pop(rsp_keep),
    .dout(sh_head), .full(sh_full), .empty(sh_empty), .count(sh_count)
  );

  // credit check, redirect target selection, enqueue/dequeue and IF/ID presentation
  always_comb begin
    redir = except_valid | eret_valid | redirect_valid;
    target = except_valid ? EXC_PC : eret_valid ? epc : redirect_pc;
    inflight = {1'b0, outstanding} + {1'b0, occ};
    imem_req_valid = rst_n & (inflight < IW'(DEPTH)) & ~halted & (pc[1:0] == 2'b00) & ~redir;
    imem_req_addr = pc;
    req_fire = imem_req_valid & imem_req_ready;
    rsp_keep = imem_rsp_valid & (drop_cnt == '0) & ~redir;
    err_push = (pc[1:0] != 2'b00) & ~halted & (outstanding == '0) & (drop_cnt == '0) & ~redir & ~q_full;
    sh_din = fetch_entry_t'{inst: '0, pc: pc, fetch_err: 1'b0};
    rsp_e = sh_head;
    rsp_e.inst = imem_rsp_data;
`ifdef MIPS_FETCH_BYPASS_EN
    bypass = q_empty & rsp_keep & id_ready;
`else
    bypass = 1'b0;
`endif
    q_din = err_push ? fetch_entry_t'{inst: '0, pc: pc, fetch_err: 1'b1} : rsp_e;
    q_push = err_push | (rsp_keep & ~bypass);
    id_sel = bypass ? rsp_e : q_head;
    id_valid = ~q_empty | bypass;
    q_pop = id_valid & id_ready & ~bypass;
    id_inst = id_valid ? id_sel.inst : '0;
    id_pc = id_valid ? id_sel.pc : '0;
    id_fetch_err = id_valid & id_sel.fetch_err;
  end

  // pc, credit counters and halt flag; on redirect every response still in flight is stale
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      halted <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redir) begin
        pc <= target;
        halted <= 1'b0;
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) pc <= pc + XLEN'(4);
        if (err_push) halted <= 1'b1;
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // response stream must respect the credits handed out
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(rsp_keep && q_full));
      assert (!(imem_rsp_valid && outstanding == '0));
      assert (!(rsp_keep && sh_empty));
      assert (!(req_fire && sh_full));
      assert (sh_count <= outstanding);
    end
  end
endmodule
